// File: rtl/game_pkg.sv
// game_pkg: state encodings, control-word type and defaults shared by the game controller and datapath.
package game_pkg;
   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_SETUP  = 3'd1,
      S_SEQ    = 3'd2,
      S_PLAY   = 3'd3,
      S_CHECK  = 3'd4,
      S_NEXT   = 3'd5,
      S_WINCHK = 3'd6,
      S_RESULT = 3'd7
   } state_t;
   localparam int SETTLE_CYCLES_DEF = 2;
   typedef struct packed {
      logic r1;
      logic r2;
      logic e1;
      logic e2;
      logic e3;
      logic e4;
      logic sel;
   } ctrl_t;
   function automatic ctrl_t ctrl_of(state_t s);
      ctrl_t c;
      c.r1  = s == S_INIT;
      c.r2  = s == S_INIT || s == S_NEXT;
      c.e1  = s == S_SETUP;
      c.e2  = s == S_PLAY;
      c.e3  = s == S_SEQ;
      c.e4  = s == S_NEXT;
      c.sel = s == S_RESULT;
      return c;
   endfunction
endpackage

// File: rtl/game_controller_if.sv
// game_controller_if: datapath status inputs and control outputs between controller and datapath.
interface game_controller_if;
   logic       end_fpga, end_user, end_time, win, match;
   logic       r1, r2, e1, e2, e3, e4, sel;
   logic [2:0] state;
   modport master (
      input  end_fpga, end_user, end_time, win, match,
      output r1, r2, e1, e2, e3, e4, sel, state
   );
   modport slave (
      output end_fpga, end_user, end_time, win, match,
      input  r1, r2, e1, e2, e3, e4, sel, state
   );
endinterface

// File: rtl/edge_detect.sv
// edge_detect: one-cycle pulse on each rising edge of a synchronized level.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);
   logic q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= 1'b0;
      else q <= d;
   assign pulse = d & ~q;
endmodule

// File: rtl/game_controller.sv
// game_controller: Moore FSM sequencing setup, playback, user entry, match check and result display.
module game_controller
   import game_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int CNT_W = 2
) (
   input logic clock_50,
   input logic reset,
   input logic enter,
   game_controller_if.master bus
);
   state_t           st, nxt;
   ctrl_t            ctrl;
   logic [CNT_W-1:0] cnt;
   logic             enter_pulse;
   logic             settled;
   edge_detect u_enter (
      .clk(clock_50),
      .rst_n(reset),
      .d(enter),
      .pulse(enter_pulse)
   );
   assign settled = cnt == CNT_W'(SETTLE_CYCLES - 1);
   // end_time is tested first so a same-cycle timeout beats a completed entry
   always_comb begin
      nxt = st;
      case (st)
         S_INIT:   nxt = S_SETUP;
         S_SETUP:  nxt = enter_pulse ? S_SEQ : S_SETUP;
         S_SEQ:    nxt = bus.end_fpga ? S_PLAY : S_SEQ;
         S_PLAY:   nxt = bus.end_time ? S_RESULT : bus.end_user ? S_CHECK : S_PLAY;
         S_CHECK:  nxt = !settled ? S_CHECK : bus.match ? S_NEXT : S_RESULT;
         S_NEXT:   nxt = S_WINCHK;
         S_WINCHK: nxt = bus.win ? S_RESULT : S_SEQ;
         S_RESULT: nxt = enter_pulse ? S_INIT : S_RESULT;
         default:  nxt = S_INIT;
      endcase
   end
   // outputs are registered from the next state so they always match st
   always_ff @(posedge clock_50 or negedge reset)
      if (!reset) begin
         st   <= S_INIT;
         cnt  <= '0;
         ctrl <= ctrl_of(S_INIT);
      end else begin
         st   <= nxt;
         cnt  <= (st == S_CHECK && nxt == S_CHECK) ? cnt + 1'b1 : '0;
         ctrl <= ctrl_of(nxt);
      end
   assign bus.r1    = ctrl.r1;
   assign bus.r2    = ctrl.r2;
   assign bus.e1    = ctrl.e1;
   assign bus.e2    = ctrl.e2;
   assign bus.e3    = ctrl.e3;
   assign bus.e4    = ctrl.e4;
   assign bus.sel   = ctrl.sel;
   assign bus.state = st;
endmodule
